// File: rtl/genevr_reg_pkg.sv
// Shared constants and state encoding for the AXI4-Lite to register-bus master.
package genevr_reg_pkg;

    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_ADDR_WIDTH     = 23;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [31:0] RD_ERR_DATA = 32'hdead_beef;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

endpackage

// File: rtl/genevr_reg_master.sv
// AXI4-Lite slave that turns one transaction at a time into a req/ack
// register-bus access, with ack timeout and full-strobe enforcement.
//
// state | meaning
// IDLE  | no transaction; registered readies offered the cycle after a valid
// REQ   | single-cycle reg_req_out strobe
// WAIT  | waiting for reg_ack_in, timeout counter running
// RESP  | bvalid/rvalid held until the AXI master takes the response
module genevr_reg_master
    import genevr_reg_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int AXI_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic                        reg_req_out,
    output logic                        reg_rd_wr_L_out,
    output logic [AXI_ADDR_WIDTH-1:0]   reg_addr_out,
    output logic [AXI_DATA_WIDTH-1:0]   reg_wr_data_out,
    input  logic                        reg_ack_in,
    input  logic [AXI_DATA_WIDTH-1:0]   reg_rd_data_in
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                    state;
    state_t                    state_next;
    logic                      wr_rdy;
    logic                      rd_rdy;
    logic                      last_rd;
    logic                      is_rd;
    logic [CNT_W-1:0]          cnt;
    logic [1:0]                resp;
    logic [AXI_DATA_WIDTH-1:0] rdata;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [AXI_DATA_WIDTH-1:0] wdata;
    logic                      rd_wr_l;

    logic wr_elig;
    logic rd_elig;
    logic strb_full;
    logic grant_wr;
    logic grant_rd;
    logic take_wr;
    logic take_rd;
    logic start_bus;
    logic ack_done;
    logic to_done;

    assign wr_elig   = s_axi_awvalid & s_axi_wvalid;
    assign rd_elig   = s_axi_arvalid;
    assign strb_full = &s_axi_wstrb;
    assign start_bus = (take_wr & strb_full) | take_rd;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ready is registered: a grant in one IDLE cycle raises ready in the next,
    // and the handshake in that cycle moves the FSM on.
    always_comb begin
        state_next = state;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        take_wr    = 1'b0;
        take_rd    = 1'b0;
        ack_done   = 1'b0;
        to_done    = 1'b0;
        case (state)
            IDLE: begin
                if (wr_rdy) begin
                    if (wr_elig) begin
                        take_wr    = 1'b1;
                        state_next = strb_full ? REQ : RESP;
                    end
                end else if (rd_rdy) begin
                    if (rd_elig) begin
                        take_rd    = 1'b1;
                        state_next = REQ;
                    end
                end else if (wr_elig && (!rd_elig || last_rd)) begin
                    grant_wr = 1'b1;
                end else if (rd_elig) begin
                    grant_rd = 1'b1;
                end
            end
            REQ: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (reg_ack_in) begin
                    ack_done   = 1'b1;
                    state_next = RESP;
                end else if (cnt == CNT_LAST) begin
                    to_done    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (is_rd ? s_axi_rready : s_axi_bready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_rdy  <= 1'b0;
            rd_rdy  <= 1'b0;
            last_rd <= 1'b1;
            is_rd   <= 1'b0;
            cnt     <= '0;
            resp    <= RESP_OKAY;
            rdata   <= '0;
            addr    <= '0;
            wdata   <= '0;
            rd_wr_l <= 1'b0;
        end else begin
            wr_rdy <= grant_wr;
            rd_rdy <= grant_rd;
            if (take_wr) begin
                last_rd <= 1'b0;
                is_rd   <= 1'b0;
                if (strb_full) begin
                    addr    <= s_axi_awaddr;
                    wdata   <= s_axi_wdata;
                    rd_wr_l <= 1'b0;
                end else begin
                    resp <= RESP_SLVERR;
                end
            end
            if (take_rd) begin
                last_rd <= 1'b1;
                is_rd   <= 1'b1;
                addr    <= s_axi_araddr;
                rd_wr_l <= 1'b1;
            end
            if (start_bus) begin
                cnt <= '0;
            end else if (state == WAIT && cnt != CNT_LAST) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (ack_done) begin
                resp <= RESP_OKAY;
                if (is_rd) begin
                    rdata <= reg_rd_data_in;
                end
            end else if (to_done) begin
                resp <= RESP_SLVERR;
                if (is_rd) begin
                    rdata <= AXI_DATA_WIDTH'(RD_ERR_DATA);
                end
            end
        end
    end

    assign s_axi_awready   = wr_rdy;
    assign s_axi_wready    = wr_rdy;
    assign s_axi_arready   = rd_rdy;
    assign s_axi_bvalid    = (state == RESP) & ~is_rd;
    assign s_axi_rvalid    = (state == RESP) & is_rd;
    assign s_axi_bresp     = resp;
    assign s_axi_rresp     = resp;
    assign s_axi_rdata     = rdata;
    assign reg_req_out     = (state == REQ);
    assign reg_rd_wr_L_out = rd_wr_l;
    assign reg_addr_out    = addr;
    assign reg_wr_data_out = wdata;

endmodule

// File: tb/tb_genevr_reg_master.sv
// Self-checking bench for genevr_reg_master: directed scenarios plus random
// transactions compared against a transaction-level reference model.
module tb_genevr_reg_master;

    localparam int TMO = 255;

    logic        clk;
    logic        reset_n;
    logic [22:0] s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [22:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic        reg_req_out;
    logic        reg_rd_wr_L_out;
    logic [22:0] reg_addr_out;
    logic [31:0] reg_wr_data_out;
    logic        reg_ack_in;
    logic [31:0] reg_rd_data_in;

    int          checks;
    int          errors;
    int          cyc;
    int          req_cnt;
    int          hold_bad;
    int          ack_delay;
    logic [31:0] rsp_data;
    bit          late_ack_on;
    logic [22:0] req_addr;
    logic        req_rdwr;
    logic [31:0] req_wdata;
    bit          model_last_rd;

    genevr_reg_master #(
        .AXI_DATA_WIDTH(32),
        .AXI_ADDR_WIDTH(23),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .s_axi_awaddr   (s_axi_awaddr),
        .s_axi_awvalid  (s_axi_awvalid),
        .s_axi_awready  (s_axi_awready),
        .s_axi_wdata    (s_axi_wdata),
        .s_axi_wstrb    (s_axi_wstrb),
        .s_axi_wvalid   (s_axi_wvalid),
        .s_axi_wready   (s_axi_wready),
        .s_axi_bresp    (s_axi_bresp),
        .s_axi_bvalid   (s_axi_bvalid),
        .s_axi_bready   (s_axi_bready),
        .s_axi_araddr   (s_axi_araddr),
        .s_axi_arvalid  (s_axi_arvalid),
        .s_axi_arready  (s_axi_arready),
        .s_axi_rdata    (s_axi_rdata),
        .s_axi_rresp    (s_axi_rresp),
        .s_axi_rvalid   (s_axi_rvalid),
        .s_axi_rready   (s_axi_rready),
        .reg_req_out    (reg_req_out),
        .reg_rd_wr_L_out(reg_rd_wr_L_out),
        .reg_addr_out   (reg_addr_out),
        .reg_wr_data_out(reg_wr_data_out),
        .reg_ack_in     (reg_ack_in),
        .reg_rd_data_in (reg_rd_data_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (reg_req_out) req_cnt <= req_cnt + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Register-bus responder: acks ack_delay cycles after req (0 = never).
    initial begin
        reg_ack_in     = 1'b0;
        reg_rd_data_in = '0;
        forever begin
            @(posedge clk); #1;
            reg_ack_in = late_ack_on;
            if (reg_req_out) begin
                req_addr  = reg_addr_out;
                req_rdwr  = reg_rd_wr_L_out;
                req_wdata = reg_wr_data_out;
                if (ack_delay > 0) begin
                    repeat (ack_delay) @(posedge clk);
                    #1;
                    if (reg_addr_out !== req_addr || reg_rd_wr_L_out !== req_rdwr ||
                        reg_wr_data_out !== req_wdata)
                        hold_bad = hold_bad + 1;
                    reg_ack_in     = 1'b1;
                    reg_rd_data_in = rsp_data;
                end
            end
        end
    end

    function automatic logic [97:0] out_bus();
        return {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
                s_axi_bresp, s_axi_rresp, s_axi_rdata, reg_req_out, reg_rd_wr_L_out,
                reg_addr_out, reg_wr_data_out};
    endfunction

    // Transaction-level expectation: response, read data, handshake-to-valid latency, req pulses.
    function automatic void ref_model(input bit wr, input logic [3:0] strb, input int dly,
                                      input logic [31:0] rd, output logic [1:0] eresp,
                                      output logic [31:0] edata, output int elat, output int ereqs);
        if (wr && strb != 4'hF) begin
            eresp = 2'b10; edata = 32'h0; elat = 1; ereqs = 0;
        end else if (dly >= 1 && dly <= TMO) begin
            eresp = 2'b00; edata = rd; elat = dly + 2; ereqs = 1;
        end else begin
            eresp = 2'b10; edata = 32'hdead_beef; elat = TMO + 2; ereqs = 1;
        end
    endfunction

    task automatic run_txn(input bit wr, input logic [22:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int dly, input logic [31:0] rd,
                           input int bp, input bit late,
                           output logic [1:0] g_resp, output logic [31:0] g_data,
                           output int g_lat, output int g_reqs, output bit g_stable);
        int t0, r0, n;
        ack_delay = dly;
        rsp_data  = rd;
        r0        = req_cnt;
        g_stable  = 1'b1;
        g_lat     = -1;
        g_resp    = 2'bxx;
        g_data    = 'x;
        @(posedge clk); #1;
        if (wr) begin
            s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
            s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        end else begin
            s_axi_araddr = addr; s_axi_arvalid = 1'b1;
        end
        n = 0;
        while (!(wr ? (s_axi_awready && s_axi_wready) : s_axi_arready) && n < 20) begin
            @(posedge clk); #1; n++;
        end
        t0 = cyc;
        model_last_rd = !wr;
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        n = 0;
        while (!(wr ? s_axi_bvalid : s_axi_rvalid) && n < 600) begin
            @(posedge clk); #1; n++;
        end
        if (n < 600) begin
            g_lat  = cyc - t0;
            g_resp = wr ? s_axi_bresp : s_axi_rresp;
            g_data = s_axi_rdata;
            late_ack_on = late;
            repeat (bp) begin
                @(posedge clk); #1;
                if (!(wr ? s_axi_bvalid : s_axi_rvalid) ||
                    (wr ? s_axi_bresp : s_axi_rresp) !== g_resp || s_axi_rdata !== g_data)
                    g_stable = 1'b0;
            end
            late_ack_on = 1'b0;
            if (wr) s_axi_bready = 1'b1; else s_axi_rready = 1'b1;
            @(posedge clk); #1;
            s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        end
        g_reqs = req_cnt - r0;
    endtask

    // Write and read presented together; order_code 12 = write first, 21 = read first.
    task automatic run_both(output int order_code, output bit tmo);
        int n, done;
        bit dw, dr;
        ack_delay = 1;
        rsp_data  = 32'h5a5a_0001;
        @(posedge clk); #1;
        s_axi_awaddr = 23'h000100; s_axi_wdata = 32'h0bad_cafe; s_axi_wstrb = 4'hF;
        s_axi_araddr = 23'h000104;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
        order_code = 0; done = 0; n = 0; dw = 1'b0; dr = 1'b0;
        while (done < 2 && n < 200) begin
            @(posedge clk); #1; n++;
            if (dw) begin s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; dw = 1'b0; end
            if (dr) begin s_axi_arvalid = 1'b0; dr = 1'b0; end
            s_axi_bready = 1'b0; s_axi_rready = 1'b0;
            if (s_axi_awready && s_axi_awvalid) begin order_code = order_code * 10 + 1; dw = 1'b1; end
            if (s_axi_arready && s_axi_arvalid) begin order_code = order_code * 10 + 2; dr = 1'b1; end
            if (s_axi_bvalid) begin s_axi_bready = 1'b1; done++; end
            if (s_axi_rvalid) begin s_axi_rready = 1'b1; done++; end
        end
        @(posedge clk); #1;
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        tmo = (done < 2);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_bus() !== '0) begin
            errors++; $display("FAIL reset_outputs got=%h want=0", out_bus());
        end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_bus() !== '0) begin
            errors++; $display("FAIL first_edge_quiet got=%h want=0", out_bus());
        end
    endtask

    task automatic test_simultaneous();
        int oc, exp;
        bit tmo;
        logic [1:0] r; logic [31:0] d; int l, q; bit s;
        for (int i = 0; i < 2; i++) begin
            exp = model_last_rd ? 12 : 21;
            run_both(oc, tmo);
            checks++;
            if (tmo || oc !== exp) begin
                errors++; $display("FAIL both_order_%0d got=%0d tmo=%0d want=%0d", i, oc, tmo, exp);
            end
            model_last_rd = (exp == 12);
        end
        run_txn(1'b1, 23'h000200, 32'h1111_2222, 4'hF, 1, 32'h0, 0, 1'b0, r, d, l, q, s);
        exp = model_last_rd ? 12 : 21;
        run_both(oc, tmo);
        checks++;
        if (tmo || oc !== exp || exp !== 21) begin
            errors++; $display("FAIL both_after_write got=%0d tmo=%0d want=%0d", oc, tmo, exp);
        end
        model_last_rd = (exp == 12);
    endtask

    task automatic test_single_write();
        logic [1:0] r; logic [31:0] d; int l, q, hb; bit s;
        hb = hold_bad;
        run_txn(1'b1, 23'h4005C0, 32'h12345678, 4'hF, 1, 32'h0, 0, 1'b0, r, d, l, q, s);
        checks++;
        if (r !== 2'b00 || l !== 3) begin
            errors++; $display("FAIL write_resp got resp=%b lat=%0d want resp=00 lat=3", r, l);
        end
        checks++;
        if (q !== 1 || req_rdwr !== 1'b0) begin
            errors++; $display("FAIL write_req got pulses=%0d rd_wr_L=%b want 1/0", q, req_rdwr);
        end
        checks++;
        if (req_addr !== 23'h4005C0 || req_wdata !== 32'h12345678 || hold_bad !== hb) begin
            errors++; $display("FAIL write_bus got addr=%h data=%h hold_bad=%0d", req_addr, req_wdata, hold_bad - hb);
        end
    endtask

    task automatic test_single_read();
        logic [1:0] r; logic [31:0] d; int l, q; bit s;
        run_txn(1'b0, 23'h4005C4, 32'h0, 4'h0, 1, 32'hCAFEF00D, 0, 1'b0, r, d, l, q, s);
        checks++;
        if (r !== 2'b00 || d !== 32'hCAFEF00D || l !== 3) begin
            errors++; $display("FAIL read_resp got resp=%b data=%h lat=%0d want 00/cafef00d/3", r, d, l);
        end
        checks++;
        if (q !== 1 || req_rdwr !== 1'b1 || req_addr !== 23'h4005C4) begin
            errors++; $display("FAIL read_req got pulses=%0d rd_wr_L=%b addr=%h", q, req_rdwr, req_addr);
        end
    endtask

    task automatic test_partial_strobe();
        logic [1:0] r; logic [31:0] d; int l, q; bit s;
        run_txn(1'b1, 23'h4005C8, 32'hAAAA5555, 4'h3, 1, 32'h0, 0, 1'b0, r, d, l, q, s);
        checks++;
        if (r !== 2'b10 || q !== 0 || l !== 1) begin
            errors++; $display("FAIL partial_strobe got resp=%b pulses=%0d lat=%0d want 10/0/1", r, q, l);
        end
    endtask

    task automatic test_timeout();
        logic [1:0] r; logic [31:0] d; int l, q; bit s;
        run_txn(1'b0, 23'h000040, 32'h0, 4'h0, 0, 32'h0, 3, 1'b1, r, d, l, q, s);
        checks++;
        if (r !== 2'b10 || d !== 32'hdead_beef || l !== TMO + 2) begin
            errors++; $display("FAIL timeout_read got resp=%b data=%h lat=%0d want 10/deadbeef/%0d", r, d, l, TMO + 2);
        end
        checks++;
        if (!s || q !== 1) begin
            errors++; $display("FAIL timeout_late_ack got stable=%0d pulses=%0d want 1/1", s, q);
        end
        run_txn(1'b0, 23'h000044, 32'h0, 4'h0, TMO, 32'h7777_8888, 0, 1'b0, r, d, l, q, s);
        checks++;
        if (r !== 2'b00 || d !== 32'h7777_8888 || l !== TMO + 2) begin
            errors++; $display("FAIL ack_last_cycle got resp=%b data=%h lat=%0d", r, d, l);
        end
        run_txn(1'b0, 23'h000048, 32'h0, 4'h0, TMO + 1, 32'h9999_0000, 0, 1'b0, r, d, l, q, s);
        checks++;
        if (r !== 2'b10 || d !== 32'hdead_beef || l !== TMO + 2) begin
            errors++; $display("FAIL ack_after_timeout got resp=%b data=%h lat=%0d", r, d, l);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] r; logic [31:0] d; int l, q; bit s;
        run_txn(1'b1, 23'h000300, 32'hFEED_F00D, 4'hF, 2, 32'h0, 10, 1'b0, r, d, l, q, s);
        checks++;
        if (!s || r !== 2'b00 || l !== 4) begin
            errors++; $display("FAIL backpressure got stable=%0d resp=%b lat=%0d want 1/00/4", s, r, l);
        end
    endtask

    task automatic test_random();
        logic [1:0] r, er; logic [31:0] d, ed, wd, rd; logic [22:0] a; logic [3:0] st;
        int l, q, el, eq, dly, hb; bit s, wr;
        for (int i = 0; i < 24; i++) begin
            wr  = 1'($urandom_range(0, 1));
            a   = 23'($urandom());
            wd  = $urandom();
            rd  = $urandom();
            st  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
            dly = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 6);
            hb  = hold_bad;
            ref_model(wr, st, dly, rd, er, ed, el, eq);
            run_txn(wr, a, wd, st, dly, rd, $urandom_range(0, 3), 1'b0, r, d, l, q, s);
            checks++;
            if (r !== er || l !== el || q !== eq || !s || hold_bad !== hb) begin
                errors++;
                $display("FAIL rand_%0d_resp got resp=%b lat=%0d req=%0d stable=%0d want resp=%b lat=%0d req=%0d",
                         i, r, l, q, s, er, el, eq);
            end
            if (!wr) begin
                checks++;
                if (d !== ed) begin
                    errors++; $display("FAIL rand_%0d_rdata got=%h want=%h", i, d, ed);
                end
            end
            if (eq == 1) begin
                checks++;
                if (req_addr !== a || req_rdwr !== !wr || (wr && req_wdata !== wd)) begin
                    errors++; $display("FAIL rand_%0d_bus got addr=%h rdwr=%b wdata=%h", i, req_addr, req_rdwr, req_wdata);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int n, r0, oc, exp;
        bit tmo;
        ack_delay = 0;
        r0 = req_cnt;
        @(posedge clk); #1;
        s_axi_awaddr = 23'h000123; s_axi_wdata = 32'h0123_4567; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        n = 0;
        while (!s_axi_awready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        checks++;
        if (req_cnt - r0 !== 1 || reg_addr_out !== 23'h000123) begin
            errors++; $display("FAIL mid_setup got pulses=%0d addr=%h want 1/000123", req_cnt - r0, reg_addr_out);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_bus() !== '0) begin
            errors++; $display("FAIL mid_reset_outputs got=%h want=0", out_bus());
        end
        @(negedge clk); reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (out_bus() !== '0) begin
            errors++; $display("FAIL mid_reset_no_resp got=%h want=0", out_bus());
        end
        model_last_rd = 1'b1;
        exp = model_last_rd ? 12 : 21;
        run_both(oc, tmo);
        checks++;
        if (tmo || oc !== exp) begin
            errors++; $display("FAIL rr_after_reset got=%0d tmo=%0d want=%0d", oc, tmo, exp);
        end
    endtask

    initial begin
        reset_n       = 1'b0;
        s_axi_awaddr  = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0; s_axi_wstrb   = '0; s_axi_wvalid = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_araddr  = '0; s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        ack_delay     = 1;
        rsp_data      = '0;
        late_ack_on   = 1'b0;
        model_last_rd = 1'b1;
        test_reset();
        test_simultaneous();
        test_single_write();
        test_single_read();
        test_partial_strobe();
        test_timeout();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/genevr_reg_master.md
GENEVR_REG_MASTER -- requirements
Module: genevr_reg_master

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 32, the data width of the AXI4-Lite and register-bus paths.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 23, the byte address width passed unmodified to the register bus.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum number of cycles to wait for reg_ack_in; the legal range is 1..1023.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; every flop is rising-edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have the AW channel: s_axi_awaddr input AXI_ADDR_WIDTH, s_axi_awvalid input 1, s_axi_awready output 1.
REQ-007 SHALL have the W channel: s_axi_wdata input AXI_DATA_WIDTH, s_axi_wstrb input AXI_DATA_WIDTH/8, s_axi_wvalid input 1, s_axi_wready output 1.
REQ-008 SHALL have the B channel: s_axi_bresp output 2, s_axi_bvalid output 1, s_axi_bready input 1.
REQ-009 SHALL have the AR channel: s_axi_araddr input AXI_ADDR_WIDTH, s_axi_arvalid input 1, s_axi_arready output 1.
REQ-010 SHALL have the R channel: s_axi_rdata output AXI_DATA_WIDTH, s_axi_rresp output 2, s_axi_rvalid output 1, s_axi_rready input 1.
REQ-011 SHALL have port reg_req_out, output, 1 bit: register-bus request strobe.
REQ-012 SHALL have port reg_rd_wr_L_out, output, 1 bit: 1 = read, 0 = write.
REQ-013 SHALL have port reg_addr_out, output, AXI_ADDR_WIDTH bits: register address (block tag plus register offset).
REQ-014 SHALL have port reg_wr_data_out, output, AXI_DATA_WIDTH bits: write data.
REQ-015 SHALL have ports reg_ack_in (input, 1 bit) and reg_rd_data_in (input, AXI_DATA_WIDTH bits): the responder acknowledge and the read data, both sampled in the same cycle.

Function
REQ-016 SHALL use FSM states IDLE, REQ, WAIT, RESP, with at most one transaction outstanding.
REQ-017 SHALL, in IDLE, accept a write only when awvalid and wvalid are both high, pulsing awready and wready together for one cycle and latching addr, data and strb.
REQ-018 SHALL, in IDLE, accept a read when arvalid is high, pulsing arready for one cycle and latching araddr.
REQ-019 SHALL, when a write and a read are both eligible in the same cycle, serve the type not served last (round-robin); after reset, write wins first.
REQ-020 SHALL, on an accepted write with wstrb not all ones, skip the bus access and go directly to RESP with SLVERR.
REQ-021 SHALL drive reg_req_out high for exactly one cycle, in REQ; the next state is WAIT.
REQ-022 SHALL hold reg_addr_out, reg_wr_data_out and reg_rd_wr_L_out stable from REQ until leaving WAIT.
REQ-023 SHALL, in WAIT, count cycles; on reg_ack_in=1 capture reg_rd_data_in (reads only), set resp OKAY (2'b00) and go to RESP.
REQ-024 SHALL, if TIMEOUT_CYCLES WAIT cycles elapse without an ack, go to RESP with SLVERR (2'b10); a timed-out read returns rdata 32'hdead_beef.
REQ-025 SHALL ignore reg_ack_in in IDLE, REQ and RESP; an ack arriving after a timeout is dropped.
REQ-026 SHALL set the timing so that with an ack on the cycle after req, the AXI handshake is at cycle T, req at T+1, ack at T+2 and bvalid/rvalid at T+3.
REQ-027 SHALL, in RESP, hold bvalid (or rvalid) with a stable resp and data until the matching ready is high, then return to IDLE on the next cycle.
REQ-028 SHALL keep awready, wready and arready low in every state except IDLE.
REQ-029 SHALL keep the timeout counter saturating: it clears on entry to REQ and never wraps.

Reset
REQ-030 SHALL, on reset_n low, asynchronously force state IDLE and drive all outputs to 0, including reg_req_out, every ready/valid, resp, rdata, reg_addr_out and reg_wr_data_out.
REQ-031 SHALL, on reset mid-transaction, abort the transaction with no AXI response issued; the round-robin pointer returns to "read served last".
REQ-032 SHALL require no output to toggle during the first clk edge after reset_n deasserts unless an AXI valid is already high.

Structure
REQ-033 SHALL place in package genevr_reg_pkg: RESP_OKAY, RESP_SLVERR, RD_ERR_DATA=32'hdead_beef, the FSM state encoding, and the default widths.
REQ-034 SHALL be implemented as one module with no sub-module; the timeout counter is an inline register of width clog2(TIMEOUT_CYCLES+1).

Verification
REQ-035 SHALL verify a single write: awaddr=23'h4005C0, wdata=32'h12345678, wstrb=4'hF, responder acks next cycle -> one req pulse, rd_wr_L=0, bresp=OKAY at T+3.
REQ-036 SHALL verify a single read: araddr=23'h4005C4, responder returns 32'hCAFEF00D -> rdata=32'hCAFEF00D, rresp=OKAY.
REQ-037 SHALL verify a timeout: a read to unmapped 23'h000040 with no ack -> rvalid after 255 WAIT cycles, rresp=SLVERR, rdata=32'hdead_beef; a late ack is ignored.
REQ-038 SHALL verify a partial strobe: wstrb=4'h3 -> no reg_req_out pulse, bresp=SLVERR.
REQ-039 SHALL verify simultaneous requests: write and read both valid after reset -> write served first, read second; with both repeated, the order alternates.
REQ-040 SHALL verify backpressure and reset: bready held low 10 cycles -> bvalid and bresp stable; reset_n asserted in WAIT -> all outputs 0 immediately.
